// File: rtl/gci_std_display_vram_arbiter.sv
// gci_std_display_vram_arbiter
// Shares the single VRAM memory-controller port between the display read path
// (requester 0) and the host read/write path (requester 1). One session is
// granted at a time. The owner stays latched until all of its reads have returned.
// Optional build macro GCI_VRAM_ARB_ROUND_ROBIN_EN: simultaneous requests go to the
// requester that did not own the previous session, instead of always to the display.
`timescale 1ns/1ps

module gci_std_display_vram_arbiter #(
    parameter int P_MEM_ADDR_N    = 19,
    parameter int P_OUTSTANDING_N = 4
)(
    input  logic                    iCLOCK,
    input  logic                    iRESET,
    input  logic                    iRESET_SYNC,
    input  logic                    iDISP_IF_REQ,
    output logic                    oDISP_IF_ACK,
    input  logic                    iDISP_IF_FINISH,
    input  logic                    iDISP_IF_ENA,
    output logic                    oDISP_IF_BUSY,
    input  logic [P_MEM_ADDR_N-1:0] iDISP_IF_ADDR,
    output logic                    oDISP_IF_VALID,
    output logic [31:0]             oDISP_IF_DATA,
    input  logic                    iHOST_IF_REQ,
    output logic                    oHOST_IF_ACK,
    input  logic                    iHOST_IF_FINISH,
    input  logic                    iHOST_IF_ENA,
    output logic                    oHOST_IF_BUSY,
    input  logic                    iHOST_IF_RW,
    input  logic [P_MEM_ADDR_N-1:0] iHOST_IF_ADDR,
    input  logic [31:0]             iHOST_IF_DATA,
    output logic                    oHOST_IF_VALID,
    output logic [31:0]             oHOST_IF_DATA,
    output logic                    oMEM_ENA,
    output logic                    oMEM_RW,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [31:0]             oMEM_DATA,
    input  logic                    iMEM_BUSY,
    input  logic                    iMEM_VALID,
    input  logic [31:0]             iMEM_DATA,
    output logic                    oERR_SPURIOUS
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_OWN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       owner;
    logic                       owner_next;
    logic [P_OUTSTANDING_N-1:0] count;
    logic                       err;
    logic                       grant_host;
    logic                       sat;
    logic                       own_ena;
    logic                       own_finish;
    logic                       own_busy;
    logic                       mem_ena;
    logic                       mem_rw;
    logic                       accept;
    logic                       count_inc;
    logic                       count_dec;
    logic                       count_zero;

`ifdef GCI_VRAM_ARB_ROUND_ROBIN_EN
    logic last_host;

    // Remember who owned the last session; after reset the host counts as last owner
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            last_host <= 1'b1;
        end else if (iRESET_SYNC) begin
            last_host <= 1'b1;
        end else if (state == ST_IDLE && (iDISP_IF_REQ || iHOST_IF_REQ)) begin
            last_host <= grant_host;
        end
    end

    // Simultaneous requests alternate; a lone request is granted directly
    always_comb begin
        if (iDISP_IF_REQ && iHOST_IF_REQ) begin
            grant_host = !last_host;
        end else begin
            grant_host = iHOST_IF_REQ;
        end
    end
`else
    // Fixed priority: the display wins whenever it is requesting
    always_comb begin
        grant_host = iHOST_IF_REQ && !iDISP_IF_REQ;
    end
`endif

    // Owner-selected command, busy and saturation terms
    always_comb begin
        count_zero = (count == '0);
        sat        = &count;
        own_ena    = owner ? iHOST_IF_ENA : iDISP_IF_ENA;
        own_finish = owner ? iHOST_IF_FINISH : iDISP_IF_FINISH;
        own_busy   = iMEM_BUSY || sat || (state != ST_OWN);
        mem_ena    = (state == ST_OWN) && own_ena && !sat;
        mem_rw     = owner ? iHOST_IF_RW : 1'b0;
        accept     = mem_ena && !iMEM_BUSY;
        count_inc  = accept && !mem_rw;
        count_dec  = iMEM_VALID && !count_zero;
    end

    // Session state register and latched owner
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= ST_IDLE;
            owner <= 1'b0;
        end else if (iRESET_SYNC) begin
            state <= ST_IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Next-state logic: grant in IDLE, one ACK cycle, own until FINISH, drain reads
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            ST_IDLE: begin
                if (iDISP_IF_REQ || iHOST_IF_REQ) begin
                    state_next = ST_ACK;
                    owner_next = grant_host;
                end
            end
            ST_ACK:   state_next = ST_OWN;
            ST_OWN: begin
                if (own_finish) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_zero) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outstanding-read counter; a read issued and a return in one cycle cancel out
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            count <= '0;
        end else if (iRESET_SYNC) begin
            count <= '0;
        end else if (count_inc && !count_dec) begin
            count <= count + 1'b1;
        end else if (count_dec && !count_inc) begin
            count <= count - 1'b1;
        end
    end

    // Sticky flag for read data that arrives with nothing outstanding
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            err <= 1'b0;
        end else if (iRESET_SYNC) begin
            err <= 1'b0;
        end else if (iMEM_VALID && count_zero) begin
            err <= 1'b1;
        end
    end

    assign oMEM_ENA       = mem_ena;
    assign oMEM_RW        = mem_rw;
    assign oMEM_ADDR      = owner ? iHOST_IF_ADDR : iDISP_IF_ADDR;
    assign oMEM_DATA      = owner ? iHOST_IF_DATA : 32'd0;

    assign oDISP_IF_ACK   = (state == ST_ACK) && !owner;
    assign oHOST_IF_ACK   = (state == ST_ACK) && owner;
    assign oDISP_IF_BUSY  = owner ? 1'b1 : own_busy;
    assign oHOST_IF_BUSY  = owner ? own_busy : 1'b1;

    assign oDISP_IF_VALID = count_dec && !owner;
    assign oHOST_IF_VALID = count_dec && owner;
    assign oDISP_IF_DATA  = iMEM_DATA;
    assign oHOST_IF_DATA  = iMEM_DATA;

    assign oERR_SPURIOUS  = err;

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// tb_gci_std_display_vram_arbiter
// Directed bench with a latency-3 memory model and a read-return scoreboard.
// Expectations follow GCI_VRAM_ARB_ROUND_ROBIN_EN when that macro is defined.
`timescale 1ns/1ps

module tb_gci_std_display_vram_arbiter;

    localparam int AW = 19;
    localparam int ON = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_sync = 1'b0;
    logic          disp_req = 1'b0;
    logic          disp_finish = 1'b0;
    logic          disp_ena = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          host_req = 1'b0;
    logic          host_finish = 1'b0;
    logic          host_ena = 1'b0;
    logic          host_rw = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [31:0]   host_wdata = '0;
    logic          mem_busy = 1'b0;
    logic          mem_valid;
    logic [31:0]   mem_rdata;

    logic          disp_ack, disp_busy, disp_valid;
    logic [31:0]   disp_rdata;
    logic          host_ack, host_busy, host_valid;
    logic [31:0]   host_rdata;
    logic          mem_ena, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          err;

    int vectors = 0;
    int miscompares = 0;
    int tb_cyc = 0;
    int valid_seen = 0;
    int last_valid_cyc = 0;

    bit          hold = 1'b0;
    logic        model_valid = 1'b0;
    logic [31:0] model_data = '0;
    logic        inj_valid = 1'b0;
    logic [31:0] model_mem [0:255];
    logic [31:0] shadow [0:255];
    int          rq_due [$];
    logic [31:0] rq_data [$];
    bit          exp_who [$];
    logic [31:0] exp_data [$];

    logic          cap_acc = 1'b0;
    logic          cap_rw = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic [31:0]   cap_wdata = '0;
    bit            mon_who;
    logic [31:0]   mon_data;

    assign mem_valid = model_valid | inj_valid;
    assign mem_rdata = model_data;

    always #5 clk = ~clk;

    gci_std_display_vram_arbiter #(
        .P_MEM_ADDR_N(AW),
        .P_OUTSTANDING_N(ON)
    ) dut (
        .iCLOCK(clk),
        .iRESET(rst),
        .iRESET_SYNC(rst_sync),
        .iDISP_IF_REQ(disp_req),
        .oDISP_IF_ACK(disp_ack),
        .iDISP_IF_FINISH(disp_finish),
        .iDISP_IF_ENA(disp_ena),
        .oDISP_IF_BUSY(disp_busy),
        .iDISP_IF_ADDR(disp_addr),
        .oDISP_IF_VALID(disp_valid),
        .oDISP_IF_DATA(disp_rdata),
        .iHOST_IF_REQ(host_req),
        .oHOST_IF_ACK(host_ack),
        .iHOST_IF_FINISH(host_finish),
        .iHOST_IF_ENA(host_ena),
        .oHOST_IF_BUSY(host_busy),
        .iHOST_IF_RW(host_rw),
        .iHOST_IF_ADDR(host_addr),
        .iHOST_IF_DATA(host_wdata),
        .oHOST_IF_VALID(host_valid),
        .oHOST_IF_DATA(host_rdata),
        .oMEM_ENA(mem_ena),
        .oMEM_RW(mem_rw),
        .oMEM_ADDR(mem_addr),
        .oMEM_DATA(mem_wdata),
        .iMEM_BUSY(mem_busy),
        .iMEM_VALID(mem_valid),
        .iMEM_DATA(mem_rdata),
        .oERR_SPURIOUS(err)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        vectors++;
        miscompares++;
        $error("[TB] FAIL %s: observed timeout expected event", tag);
    endtask

    // Command capture away from the edge, then memory behaviour on the edge
    always @(negedge clk) begin
        cap_acc   = mem_ena && !mem_busy;
        cap_rw    = mem_rw;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
    end

    always @(posedge clk) begin
        tb_cyc++;
        if (cap_acc) begin
            if (cap_rw) begin
                model_mem[cap_addr[7:0]] = cap_wdata;
            end else begin
                rq_due.push_back(tb_cyc + 2);
                rq_data.push_back(model_mem[cap_addr[7:0]]);
            end
        end
        if (!hold && rq_due.size() > 0 && rq_due[0] <= tb_cyc) begin
            model_valid <= 1'b1;
            model_data  <= rq_data[0];
            void'(rq_due.pop_front());
            void'(rq_data.pop_front());
        end else begin
            model_valid <= 1'b0;
        end
    end

    // Scoreboard: every VALID must match the oldest expected read
    always @(negedge clk) begin
        if (disp_valid || host_valid) begin
            valid_seen++;
            last_valid_cyc = tb_cyc;
            if (exp_who.size() == 0) begin
                check_output("unexpected_valid", {62'd0, disp_valid, host_valid}, 64'd0);
            end else begin
                mon_who  = exp_who.pop_front();
                mon_data = exp_data.pop_front();
                check_output("valid_route", {62'd0, disp_valid, host_valid}, mon_who ? 64'd1 : 64'd2);
                check_output("read_data", mon_who ? host_rdata : disp_rdata, mon_data);
            end
        end
    end

    task automatic issue(input bit who, input bit rw, input int addr, input logic [31:0] wd);
        int n;
        if (who) begin
            host_ena = 1'b1; host_rw = rw; host_addr = addr[AW-1:0]; host_wdata = wd;
        end else begin
            disp_ena = 1'b1; disp_addr = addr[AW-1:0];
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_ena && !mem_busy) break;
            n++;
            if (n > 40) break;
            @(posedge clk); #1;
        end
        if (n > 40) begin
            timeout_fail("issue_timeout");
        end else begin
            check_output("cmd_addr", mem_addr, addr[AW-1:0]);
            check_output("cmd_rw", mem_rw, rw);
            if (rw) begin
                check_output("cmd_wdata", mem_wdata, wd);
                shadow[addr[7:0]] = wd;
            end else begin
                exp_who.push_back(who);
                exp_data.push_back(shadow[addr[7:0]]);
            end
        end
        @(posedge clk); #1;
        disp_ena = 1'b0;
        host_ena = 1'b0;
    endtask

    task automatic wait_ack(output int n, output bit got_host, output int ack_cyc);
        n = 0; got_host = 1'b0; ack_cyc = 0;
        forever begin
            @(negedge clk);
            if (disp_ack || host_ack) break;
            n++;
            if (n > 60) break;
            @(posedge clk); #1;
            disp_finish = 1'b0;
            host_finish = 1'b0;
        end
        if (n > 60) begin
            timeout_fail("ack_timeout");
        end else begin
            check_output("ack_onehot", disp_ack && host_ack, 1'b0);
            got_host = host_ack;
            ack_cyc  = tb_cyc;
        end
        @(posedge clk); #1;
        disp_finish = 1'b0;
        host_finish = 1'b0;
        if (got_host) host_req = 1'b0;
        else disp_req = 1'b0;
    endtask

    task automatic end_session(input bit who);
        if (who) host_finish = 1'b1;
        else disp_finish = 1'b1;
        @(posedge clk); #1;
        disp_finish = 1'b0;
        host_finish = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_returns();
        int k;
        k = 0;
        while (exp_who.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        if (k >= 50) timeout_fail("return_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, ack_cyc, vs;
        bit gh;
        bit exp_rr_host;

        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'hC0DE_0000 | i;
            shadow[i]    = 32'hC0DE_0000 | i;
        end
`ifdef GCI_VRAM_ARB_ROUND_ROBIN_EN
        exp_rr_host = 1'b1;
`else
        exp_rr_host = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_disp_ack", disp_ack, 1'b0);
        check_output("rst_host_ack", host_ack, 1'b0);
        check_output("rst_disp_valid", disp_valid, 1'b0);
        check_output("rst_host_valid", host_valid, 1'b0);
        check_output("rst_mem_ena", mem_ena, 1'b0);
        check_output("rst_disp_busy", disp_busy, 1'b1);
        check_output("rst_host_busy", host_busy, 1'b1);
        check_output("rst_err", err, 1'b0);
        @(posedge clk); #1;

        // Simultaneous requests: display first, host 3 cycles after display FINISH
        disp_req = 1'b1; host_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("sim_first_owner", gh, 1'b0);
        check_output("sim_req_to_ack", n, 1);
        check_output("own_disp_busy", disp_busy, 1'b0);
        check_output("own_host_busy", host_busy, 1'b1);
        disp_finish = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("sim_second_owner", gh, 1'b1);
        check_output("finish_to_ack", n, 3);

        // Host write then re-request: an empty drain proves the write was not counted
        issue(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
        host_finish = 1'b1; host_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("write_drain_owner", gh, 1'b1);
        check_output("write_drain_cycles", n, 3);
        issue(1'b1, 1'b0, 5, 32'd0);
        issue(1'b1, 1'b0, 6, 32'd0);
        host_finish = 1'b1; disp_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("after_host_owner", gh, 1'b0);

        // Repeated simultaneous request while display ends its session
        disp_finish = 1'b1; disp_req = 1'b1; host_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("repeat_sim_owner", gh, exp_rr_host);
        check_output("repeat_sim_cycles", n, 3);
        disp_req = 1'b0; host_req = 1'b0;
        end_session(gh);

        // Display-only session with four reads; drain ends after the fourth return
        disp_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("disp_only_owner", gh, 1'b0);
        check_output("disp_only_req_to_ack", n, 1);
        vs = valid_seen;
        for (int a = 0; a < 4; a++) issue(1'b0, 1'b0, a, 32'd0);
        disp_finish = 1'b1; disp_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("disp_only_valid_count", valid_seen - vs, 4);
        check_output("drain_to_ack", ack_cyc - last_valid_cyc, 3);

        // Saturation: three reads outstanding block a fourth until a return arrives
        hold = 1'b1;
        for (int a = 16; a < 19; a++) issue(1'b0, 1'b0, a, 32'd0);
        disp_ena = 1'b1; disp_addr = 19;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output("sat_busy", disp_busy, 1'b1);
            check_output("sat_no_ena", mem_ena, 1'b0);
        end
        hold = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 19, 32'd0);
        wait_returns();
        end_session(1'b0);

        // Spurious return in IDLE sets the sticky flag; async reset clears it
        check_output("err_before", err, 1'b0);
        inj_valid = 1'b1;
        @(posedge clk); #1 inj_valid = 1'b0;
        @(negedge clk);
        check_output("err_set", err, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_output("async_err_clear", err, 1'b0);
        check_output("async_busy", disp_busy, 1'b1);
        @(posedge clk); #1 rst = 1'b0;

        // Sync reset mid-session with two reads pending
        disp_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        hold = 1'b1;
        issue(1'b0, 1'b0, 32, 32'd0);
        issue(1'b0, 1'b0, 33, 32'd0);
        rst_sync = 1'b1;
        @(posedge clk); #1 rst_sync = 1'b0;
        exp_who.delete();
        exp_data.delete();
        @(negedge clk);
        check_output("sync_disp_busy", disp_busy, 1'b1);
        check_output("sync_mem_ena", mem_ena, 1'b0);
        check_output("sync_disp_ack", disp_ack, 1'b0);
        check_output("sync_err", err, 1'b0);
        @(posedge clk); #1;
        disp_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("sync_idle_req_to_ack", n, 1);
        hold = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_output("sync_late_err", err, 1'b1);
        @(posedge clk); #1;
        disp_finish = 1'b1; disp_req = 1'b1;
        wait_ack(n, gh, ack_cyc);
        check_output("sync_counter_zero", n, 3);
        end_session(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gci_std_display_vram_arbiter.md
Name: gci_std_display_vram_arbiter

Overview:
- Single-clock arbiter that shares the one VRAM memory-controller port between two requesters.
  - Requester 0 is the display read path.
  - Requester 1 is the host read/write path.
- Each requester uses the REQ/ACK/FINISH session handshake with ENA/BUSY/ADDR/VALID/DATA transfers.
- The arbiter grants one session at a time and muxes the owner onto the memory port.
- It returns read data to the owner and does not re-grant until all outstanding reads have returned.

Parameters:
P_MEM_ADDR_N, 19, VRAM word address width
P_OUTSTANDING_N, 4, outstanding-read counter width; maximum outstanding reads = 2^P_OUTSTANDING_N - 1

Ports:
iCLOCK  in  1  system clock; all logic on the rising edge
iRESET  in  1  asynchronous, active-high reset
iRESET_SYNC  in  1  synchronous clear, same effect as iRESET
iDISP_IF_REQ  in  1  display session request
oDISP_IF_ACK  out  1  display grant pulse
iDISP_IF_FINISH  in  1  display session end
iDISP_IF_ENA  in  1  display read command
oDISP_IF_BUSY  out  1  display backpressure
iDISP_IF_ADDR  in  P_MEM_ADDR_N  display read address
oDISP_IF_VALID  out  1  display read data valid
oDISP_IF_DATA  out  32  display read data
iHOST_IF_REQ / oHOST_IF_ACK / iHOST_IF_FINISH / iHOST_IF_ENA / oHOST_IF_BUSY  1 each  same meaning as the display equivalents
iHOST_IF_RW  in  1  1 = write, 0 = read
iHOST_IF_ADDR  in  P_MEM_ADDR_N  host address
iHOST_IF_DATA  in  32  host write data
oHOST_IF_VALID  out  1  host read data valid
oHOST_IF_DATA  out  32  host read data
oMEM_ENA  out  1  command to memory controller
oMEM_RW  out  1  1 = write
oMEM_ADDR  out  P_MEM_ADDR_N  command address
oMEM_DATA  out  32  write data
iMEM_BUSY  in  1  memory not accepting commands
iMEM_VALID  in  1  read data return
iMEM_DATA  in  32  read data
oERR_SPURIOUS  out  1  sticky flag: VALID received with no read outstanding

Behaviour:
- Reset (iRESET async or iRESET_SYNC sync):
  - State = IDLE, owner register = display, counter = 0, oERR_SPURIOUS = 0.
  - Resulting outputs: all ACK/VALID = 0, oMEM_ENA = 0, both BUSY = 1.
  - Reset mid-session abandons the session; in-flight read returns are then counted as spurious.
- State machine (2-bit):
  - IDLE: if any REQ is high, latch the owner, go to ACK. Both REQ high: display wins (fixed priority).
  - ACK: one cycle; the owner's ACK = 1. Go to OWN. ENA and FINISH are ignored in this state.
  - OWN: owner commands are forwarded. On owner FINISH, go to DRAIN.
  - DRAIN: no commands forwarded. Go to IDLE when counter == 0; if counter is already 0, this happens on the next edge.
  - Minimum cycle spacing: REQ to ACK is 1 cycle; FINISH to next possible ACK is 3 cycles.
- Command path (combinational):
  - oMEM_ENA = (state == OWN) && owner ENA && !sat.
  - oMEM_RW = owner RW; display is always 0.
  - oMEM_ADDR and oMEM_DATA come from the owner. Display write data is 0.
- Busy:
  - Owner BUSY = iMEM_BUSY || sat || state != OWN.
  - Non-owner BUSY = 1.
  - A command is accepted when oMEM_ENA && !iMEM_BUSY.
- Counter and saturation:
  - sat = (counter == all-ones).
  - +1 on an accepted read; −1 on iMEM_VALID with counter != 0; both in the same cycle leaves it unchanged.
  - Writes are not counted.
- Returns:
  - Owner VALID = iMEM_VALID && counter != 0; non-owner VALID = 0.
  - Both DATA outputs = iMEM_DATA.
  - The owner register is held through DRAIN, so returns route to the session that issued them.
- Error: iMEM_VALID with counter == 0 is dropped and sets oERR_SPURIOUS, which stays set until reset.
- FINISH and ENA in the same OWN cycle: the command is accepted if not busy, and the state still goes to DRAIN.
- A REQ arriving while a session is active is held pending and arbitrated in IDLE.

Optional Feature:
- Macro GCI_VRAM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous REQ in IDLE, the grant goes to the requester that did not own the previous session. After reset, the previous owner counts as host, so display wins first.
- Undefined: fixed display priority as described above.

Test Plan:
- Display-only session:
  - Stimulus: REQ, then 4 reads at addresses 0..3 with memory returning after 3 cycles, then FINISH.
  - Required: ACK 1 cycle after REQ; oMEM_ADDR 0..3; 4 oDISP_IF_VALID; DRAIN lasts until the 4th return; then IDLE.
- Simultaneous REQ from both, no macro:
  - Required: display ACK first; host ACK 3 cycles after display FINISH when drain is empty.
- Same stimulus with GCI_VRAM_ARB_ROUND_ROBIN_EN:
  - Required: display first, then on a repeated simultaneous REQ, host first.
- Saturation with P_OUTSTANDING_N = 2 and memory returns withheld:
  - Required: 3 reads accepted, oDISP_IF_BUSY = 1 and no 4th oMEM_ENA; one return re-enables issue.
- Host write then read:
  - Required: oMEM_RW = 1 then 0; counter stays 0 for the write; read data appears on oHOST_IF_VALID/DATA; oDISP_IF_VALID stays 0.
- Error and reset:
  - iMEM_VALID in IDLE sets oERR_SPURIOUS.
  - iRESET_SYNC during OWN with 2 reads pending returns to IDLE with counter = 0; the later returns set the error flag.
